seq_mag_comparator: RTL



---
 rtl/seq_mag_comparator.sv | 102 ++++++++++
 1 files changed

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle, MSB first, stopping on the first differing chunk.
// Optional two's-complement compare is built only when SEQ_CMP_SIGNED_EN is defined.
module seq_mag_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_cap, b_cap;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [IDX_W-1:0]   idx;
    logic [CHUNK-1:0]   a_chunk, b_chunk;
    logic               chunk_gt, chunk_lt, last_chunk, finish, accept;

`ifdef SEQ_CMP_SIGNED_EN
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign a_cap = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
    assign b_cap = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign a_cap = a;
    assign b_cap = b;
`endif

    assign accept     = (state == IDLE) && start;
    assign a_chunk    = a_q[idx*CHUNK +: CHUNK];
    assign b_chunk    = b_q[idx*CHUNK +: CHUNK];
    assign chunk_gt   = a_chunk > b_chunk;
    assign chunk_lt   = a_chunk < b_chunk;
    assign last_chunk = (idx == '0);
    assign finish     = chunk_gt || chunk_lt || last_chunk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)  state_nxt = RUN;
            RUN:  if (finish) state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // Operand latches carry no reset: they are only read after a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a_cap;
            b_q <= b_cap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            done <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
            gt   <= 1'b0;
        end else if (accept) begin
            idx  <= IDX_W'(NCHUNK - 1);
            done <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
            gt   <= 1'b0;
        end else if (state == RUN) begin
            done <= finish;
            if (finish) begin
                gt <= chunk_gt;
                lt <= chunk_lt;
                eq <= !chunk_gt && !chunk_lt;
            end else begin
                idx <= idx - 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end
endmodule
